multicycle_control: RTL

Main control unit for the multicycle CPU: a Moore state machine that sequences the shared datapath (PC, memory, IR, register file, sign/zero extender, ALU, ALUOut) through fetch, decode, execute, memory and write-back steps. It reads the opcode held in IR and the ALU zero flag. It drives every mux select, write enable and ALU operation code, plus the extender mode, so each instruction reuses the single ALU and memory over 3–5 cycles.

---
 rtl/mc_pkg.sv | 77 +++++++
 rtl/multicycle_control_if.sv | 41 ++++
 rtl/mc_state_decode.sv | 96 +++++++++
 rtl/multicycle_control.sv | 74 +++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit.
// Opcodes, FSM states, ALU and mux select codes.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_EXT  = 2'b10;
  localparam logic [1:0] SRCB_EXT4 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_supported(
    input logic [5:0] op
  );
    case (op)
      OP_R, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit to datapath bundle.
// master = control unit, slave = datapath.
interface multicycle_control_if;

  logic [5:0] op;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       ext_op;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, zero,
    output pc_en, iord, mem_read, mem_write,
    output ir_write, mem_to_reg, reg_dst,
    output reg_write, alu_src_a, alu_src_b,
    output alu_op, pc_source, ext_op,
    output instr_done, illegal
  );

  modport slave (
    output op, zero,
    input  pc_en, iord, mem_read, mem_write,
    input  ir_write, mem_to_reg, reg_dst,
    input  reg_write, alu_src_a, alu_src_b,
    input  alu_op, pc_source, ext_op,
    input  instr_done, illegal
  );

endinterface

// File: rtl/mc_state_decode.sv
// Pure combinational state/op -> control word.
// Unlisted outputs stay 0 in every state.
module mc_state_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  output ctrl_t      ctrl
);

  // Moore control word per state (branch/imm use op/zero)
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.pc_en     = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_EXT4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ext_op    = 1'b1;
        ctrl.illegal   = ~op_supported(op);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_EXT;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_source  = PCS_ALUOUT;
        ctrl.instr_done = 1'b1;
        ctrl.pc_en      = (op == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        ctrl.pc_source  = PCS_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_EXT;
        ctrl.ext_op    = 1'b1;
        unique case (op)
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          OP_ANDI: begin
            ctrl.alu_op = ALU_AND;
            ctrl.ext_op = 1'b0;
          end
          OP_ORI: begin
            ctrl.alu_op = ALU_OR;
            ctrl.ext_op = 1'b0;
          end
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM.
// State register, next-state logic, reset gating.
module multicycle_control
  import mc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  state_t state;
  state_t state_nx;
  ctrl_t  ctrl;

  // State register, synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Next-state sequencing by opcode
  always_comb begin
    state_nx = S_FETCH;
    unique case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        unique case (bus.op)
          OP_LW, OP_SW:   state_nx = S_MEM_ADDR;
          OP_R:           state_nx = S_R_EXEC;
          OP_BEQ, OP_BNE: state_nx = S_BRANCH;
          OP_J:           state_nx = S_JUMP;
          OP_ADDI, OP_SLTI,
          OP_ANDI, OP_ORI: state_nx = S_I_EXEC;
          default:        state_nx = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        state_nx = (bus.op == OP_SW) ?
                   S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: state_nx = S_MEM_WB;
      S_R_EXEC:   state_nx = S_R_WB;
      S_I_EXEC:   state_nx = S_I_WB;
      default:    state_nx = S_FETCH;
    endcase
  end

  mc_state_decode u_dec (
    .state (state),
    .op    (bus.op),
    .zero  (bus.zero),
    .ctrl  (ctrl)
  );

  // Write enables are held off while reset is asserted
  always_comb begin
    bus.pc_en      = ctrl.pc_en & ~rst;
    bus.ir_write   = ctrl.ir_write & ~rst;
    bus.mem_write  = ctrl.mem_write & ~rst;
    bus.reg_write  = ctrl.reg_write & ~rst;
    bus.iord       = ctrl.iord;
    bus.mem_read   = ctrl.mem_read;
    bus.mem_to_reg = ctrl.mem_to_reg;
    bus.reg_dst    = ctrl.reg_dst;
    bus.alu_src_a  = ctrl.alu_src_a;
    bus.alu_src_b  = ctrl.alu_src_b;
    bus.alu_op     = ctrl.alu_op;
    bus.pc_source  = ctrl.pc_source;
    bus.ext_op     = ctrl.ext_op;
    bus.instr_done = ctrl.instr_done;
    bus.illegal    = ctrl.illegal;
  end

endmodule
